// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array read-side datapath.
// No logic; widths here are the defaults the drain parameters pick up.
// Consumers may override DATA_WIDTH/COLS through module parameters.
package systolic_pkg;
   localparam int DATA_WIDTH_DEF = 16;
   localparam int COLS_DEF       = 4;

   typedef logic [DATA_WIDTH_DEF-1:0] psum_t;
   typedef psum_t [COLS_DEF-1:0]      psum_vec_t;
endpackage

// File: rtl/psum_drain_fifo.sv
// Synchronous FIFO holding aligned psum vectors, with registered occupancy count.
// Latency: a write is visible on rd_data the following cycle; rd_data is mem[rd_ptr].
// Backpressure: a write when full is accepted only if a pop happens the same cycle.
module psum_drain_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_rd;
   logic             do_wr;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_rd   = rd_en & ~empty;
   // Pop is taken first, so a full FIFO still accepts a same-cycle write.
   assign do_wr   = wr_en & (~full | do_rd);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_wr) - CW'(do_rd);
      end
   end
endmodule

// File: rtl/systolic_psum_drain.sv
// De-skews bottom-row psums into aligned vectors and buffers them; DRAIN_ROW_MAX_EN adds out_max.
// Latency: inject at t, FIFO write at t+ROWS+COLS-1, out_valid no earlier than t+ROWS+COLS.
// Backpressure: out_valid/out_ready downstream; array_ready credit upstream, drops on overflow.
module systolic_psum_drain
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ROWS       = 4,
   parameter int COLS       = COLS_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     array_valid,
   input  logic [COLS*DATA_WIDTH-1:0] psum_bottom,
   output logic                     array_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [COLS*DATA_WIDTH-1:0] out_data,
   output logic                     overflow
`ifdef DRAIN_ROW_MAX_EN
   ,
   output logic [DATA_WIDTH-1:0]    out_max
`endif
);
   localparam int TAPS = ROWS + COLS - 1;
   localparam int IW   = $clog2(TAPS + 1);
   localparam int CW   = $clog2(FIFO_DEPTH + 1);
   localparam int VW   = COLS * DATA_WIDTH;
`ifdef DRAIN_ROW_MAX_EN
   localparam int EW   = VW + DATA_WIDTH;
`else
   localparam int EW   = VW;
`endif

   logic [TAPS-1:0]       vld_sr;
   logic [IW-1:0]         inflight;
   logic [DATA_WIDTH-1:0] col_wr [COLS];
   logic [EW-1:0]         wr_entry;
   logic [EW-1:0]         rd_entry;
   logic [EW-1:0]         hold_entry;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  wr_en;
   logic                  rd_en;

   // vld_sr[k] is high k+1 cycles after the injection that set it.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_sr   <= '0;
         inflight <= '0;
      end else begin
         vld_sr[0] <= array_valid;
         for (int k = 1; k < TAPS; k++) begin
            vld_sr[k] <= vld_sr[k-1];
         end
         inflight <= inflight + IW'(array_valid) - IW'(vld_sr[TAPS-1]);
      end
   end

   // Column j arrives j cycles after column 0, so it waits COLS-1-j cycles to line up.
   for (genvar j = 0; j < COLS - 1; j++) begin : g_dly
      localparam int N = COLS - 1 - j;
      logic [DATA_WIDTH-1:0] line [N];
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int s = 0; s < N; s++) begin
               line[s] <= '0;
            end
         end else begin
            line[0] <= psum_bottom[j*DATA_WIDTH +: DATA_WIDTH];
            for (int s = 1; s < N; s++) begin
               line[s] <= line[s-1];
            end
         end
      end
      assign col_wr[j] = line[N-1];
   end
   assign col_wr[COLS-1] = psum_bottom[(COLS-1)*DATA_WIDTH +: DATA_WIDTH];

`ifdef DRAIN_ROW_MAX_EN
   logic [DATA_WIDTH-1:0] row_max;
   always_comb begin
      row_max = col_wr[0];
      for (int j = 1; j < COLS; j++) begin
         if ($signed(col_wr[j]) > $signed(row_max)) begin
            row_max = col_wr[j];
         end
      end
   end
`endif

   always_comb begin
      wr_entry = '0;
      for (int j = 0; j < COLS; j++) begin
         wr_entry[j*DATA_WIDTH +: DATA_WIDTH] = col_wr[j];
      end
`ifdef DRAIN_ROW_MAX_EN
      wr_entry[EW-1 -: DATA_WIDTH] = row_max;
`endif
   end

   assign wr_en       = vld_sr[TAPS-1];
   assign out_valid   = ~fifo_empty;
   assign rd_en       = out_valid & out_ready;
   assign array_ready = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;

   psum_drain_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_entry),
      .rd_en   (rd_en),
      .rd_data (rd_entry),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Last popped entry keeps the outputs steady while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_entry <= '0;
         overflow   <= 1'b0;
      end else begin
         if (rd_en) begin
            hold_entry <= rd_entry;
         end
         if (wr_en && fifo_full && !rd_en) begin
            overflow <= 1'b1;
         end
      end
   end

   assign out_data = fifo_empty ? hold_entry[VW-1:0] : rd_entry[VW-1:0];
`ifdef DRAIN_ROW_MAX_EN
   assign out_max  = fifo_empty ? hold_entry[EW-1 -: DATA_WIDTH] : rd_entry[EW-1 -: DATA_WIDTH];
`endif
endmodule

// File: tb/tb_systolic_psum_drain.sv
// Scoreboard bench for systolic_psum_drain: skewed psums driven from an injection history.
// Expected vectors queue at injection and are compared when the DUT hands one off.
module tb_systolic_psum_drain;
   localparam int DW    = 16;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            array_valid;
   logic [63:0]     psum_bottom;
   logic            array_ready;
   logic            out_valid;
   logic            out_ready;
   logic [63:0]     out_data;
   logic            overflow;
`ifdef DRAIN_ROW_MAX_EN
   logic [DW-1:0]   out_max;
`endif

   systolic_psum_drain #(
      .DATA_WIDTH (DW),
      .ROWS       (ROWS),
      .COLS       (COLS),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .array_valid (array_valid),
      .psum_bottom (psum_bottom),
      .array_ready (array_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .overflow    (overflow)
`ifdef DRAIN_ROW_MAX_EN
      ,
      .out_max     (out_max)
`endif
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          passed = 0;
   int          cyc    = 0;
   logic [63:0] exp_q [$];
   logic        hist_v [256];
   logic [63:0] hist_d [256];

   // One cycle: drive inputs at the negedge, score any handoff, advance to next negedge.
   task automatic tick(input logic inj, input logic [63:0] vec, input logic ordy);
      int s;
      logic [63:0] exp;
      array_valid = inj;
      out_ready   = ordy;
      hist_v[cyc % 256] = inj;
      hist_d[cyc % 256] = vec;
      for (int j = 0; j < COLS; j++) begin
         s = cyc - ROWS - j;
         if (s >= 0 && hist_v[s % 256])
            psum_bottom[j*DW +: DW] = hist_d[s % 256][j*DW +: DW];
         else
            psum_bottom[j*DW +: DW] = DW'($urandom);
      end
      if (out_valid && ordy) begin
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got out_data=%h, expected no vector", out_data);
         end else begin
            exp = exp_q.pop_front();
            if (out_data !== exp)
               $display("FAIL sb_data: got %h, expected %h", out_data, exp);
            else
               passed++;
         end
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(1'b0, 64'h0, 1'b0);
      tick(1'b0, 64'h0, 1'b0);
      reset = 1'b0;
      exp_q.delete();
   endtask

   function automatic logic [63:0] rand_vec();
      return {$urandom, $urandom};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick(1'b0, 64'h0, 1'b0);
      tick(1'b0, 64'h0, 1'b0);
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, expected 0", out_valid); else passed++;
      checks++; if (array_ready !== 1'b1) $display("FAIL rst_array_ready: got %b, expected 1", array_ready); else passed++;
      checks++; if (out_data !== 64'h0) $display("FAIL rst_out_data: got %h, expected 0", out_data); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b, expected 0", overflow); else passed++;
`ifdef DRAIN_ROW_MAX_EN
      checks++; if (out_max !== 16'h0) $display("FAIL rst_out_max: got %h, expected 0", out_max); else passed++;
`endif
      reset = 1'b0;
   endtask

   task automatic test_single();
      logic [63:0] v;
      do_reset();
      v = {16'd13, 16'd12, 16'd11, 16'd10};
      exp_q.push_back(v);
      tick(1'b1, v, 1'b0);
      repeat (6) tick(1'b0, 64'h0, 1'b0);
      checks++; if (out_valid !== 1'b0) $display("FAIL single_early: out_valid=%b at t+7, expected 0", out_valid); else passed++;
      tick(1'b0, 64'h0, 1'b0);
      checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: out_valid=%b at t+8, expected 1", out_valid); else passed++;
      checks++; if (out_data !== 64'h000d_000c_000b_000a) $display("FAIL single_data: got %h, expected 000d000c000b000a", out_data); else passed++;
      tick(1'b0, 64'h0, 1'b1);
      checks++; if (out_valid !== 1'b0) $display("FAIL single_empty: out_valid=%b, expected 0", out_valid); else passed++;
      checks++; if (out_data !== 64'h000d_000c_000b_000a) $display("FAIL single_hold: got %h, expected 000d000c000b000a", out_data); else passed++;
      checks++; if (exp_q.size() != 0) $display("FAIL single_left: %0d vectors unmatched, expected 0", exp_q.size()); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] v;
      do_reset();
      for (int k = 0; k < 4; k++) begin
         v = rand_vec();
         exp_q.push_back(v);
         tick(1'b1, v, 1'b1);
      end
      repeat (4) tick(1'b0, 64'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: out_valid=%b for vector %0d, expected 1", out_valid, k); else passed++;
         tick(1'b0, 64'h0, 1'b1);
      end
      checks++; if (out_valid !== 1'b0) $display("FAIL b2b_tail: out_valid=%b, expected 0", out_valid); else passed++;
      checks++; if (exp_q.size() != 0) $display("FAIL b2b_left: %0d vectors unmatched, expected 0", exp_q.size()); else passed++;
   endtask

   task automatic test_credit();
      logic [63:0] v;
      int n = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         if (array_ready) begin
            v = rand_vec();
            exp_q.push_back(v);
            n++;
            tick(1'b1, v, 1'b0);
         end else begin
            tick(1'b0, 64'h0, 1'b0);
         end
      end
      checks++; if (n != 4) $display("FAIL credit_count: %0d injections granted, expected 4", n); else passed++;
      checks++; if (array_ready !== 1'b0) $display("FAIL credit_ready: got %b, expected 0", array_ready); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL credit_ovf: got %b, expected 0", overflow); else passed++;
      repeat (6) tick(1'b0, 64'h0, 1'b1);
      checks++; if (exp_q.size() != 0) $display("FAIL credit_left: %0d vectors unmatched, expected 0", exp_q.size()); else passed++;
      checks++; if (array_ready !== 1'b1) $display("FAIL credit_return: got %b, expected 1", array_ready); else passed++;
   endtask

   // Fill with 4 back-to-back vectors, force a 5th at t+4; pop_at_wr pops during its write.
   task automatic fill_and_force(input logic pop_at_wr, output logic ready_at_force);
      logic [63:0] v;
      int t;
      t = cyc;
      for (int k = 0; k < 4; k++) begin
         v = rand_vec();
         exp_q.push_back(v);
         tick(1'b1, v, 1'b0);
      end
      ready_at_force = array_ready;
      v = rand_vec();
      if (pop_at_wr) exp_q.push_back(v);
      tick(1'b1, v, 1'b0);
      while (cyc < t + 11) tick(1'b0, 64'h0, 1'b0);
      tick(1'b0, 64'h0, pop_at_wr);
   endtask

   task automatic test_overflow();
      logic rdy;
      do_reset();
      fill_and_force(1'b0, rdy);
      checks++; if (rdy !== 1'b0) $display("FAIL ovf_ready: array_ready=%b at forced inject, expected 0", rdy); else passed++;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", overflow); else passed++;
      repeat (8) tick(1'b0, 64'h0, 1'b1);
      checks++; if (exp_q.size() != 0) $display("FAIL ovf_left: %0d vectors unmatched, expected 0", exp_q.size()); else passed++;
      checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, expected 1", overflow); else passed++;
      checks++; if (out_valid !== 1'b0) $display("FAIL ovf_drained: out_valid=%b, expected 0", out_valid); else passed++;
   endtask

   task automatic test_full_pop();
      logic rdy;
      do_reset();
      fill_and_force(1'b1, rdy);
      checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b, expected 0", overflow); else passed++;
      checks++; if (out_valid !== 1'b1) $display("FAIL fullpop_valid: got %b, expected 1", out_valid); else passed++;
      repeat (8) tick(1'b0, 64'h0, 1'b1);
      checks++; if (exp_q.size() != 0) $display("FAIL fullpop_left: %0d vectors unmatched, expected 0", exp_q.size()); else passed++;
   endtask

   task automatic test_stall();
      logic [63:0] v;
      logic [63:0] saved;
      logic        ordy;
      logic        stalled;
      int n = 0;
      int bad = 0;
      do_reset();
      for (int i = 0; i < 400 && !(n == 12 && exp_q.size() == 0); i++) begin
         ordy    = 1'($urandom_range(0, 1));
         stalled = out_valid && !ordy;
         saved   = out_data;
         v = rand_vec();
         if (n < 12 && array_ready) begin
            exp_q.push_back(v);
            n++;
            tick(1'b1, v, ordy);
         end else begin
            tick(1'b0, 64'h0, ordy);
         end
         if (stalled) begin
            checks++;
            if (out_data !== saved || out_valid !== 1'b1) begin
               bad++;
               if (bad < 4) $display("FAIL stall_hold: got %h/%b, expected %h/1", out_data, out_valid, saved);
            end else passed++;
         end
      end
      checks++; if (n != 12 || exp_q.size() != 0) $display("FAIL stall_done: %0d injected, %0d unmatched, expected 12 and 0", n, exp_q.size()); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL stall_ovf: got %b, expected 0", overflow); else passed++;
   endtask

   task automatic test_reset_midflight();
      logic seen = 1'b0;
      int t;
      do_reset();
      tick(1'b1, rand_vec(), 1'b0);
      repeat (9) tick(1'b0, 64'h0, 1'b0);
      checks++; if (out_valid !== 1'b1) $display("FAIL mid_buffered: out_valid=%b, expected 1", out_valid); else passed++;
      t = cyc;
      tick(1'b1, rand_vec(), 1'b0);
      while (cyc < t + 5) tick(1'b0, 64'h0, 1'b0);
      reset = 1'b1;
      tick(1'b0, 64'h0, 1'b0);
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %b, expected 0", out_valid); else passed++;
      checks++; if (array_ready !== 1'b1) $display("FAIL mid_ready: got %b, expected 1", array_ready); else passed++;
      for (int i = 0; i < 15; i++) begin
         seen = seen | out_valid;
         tick(1'b0, 64'h0, 1'b1);
      end
      checks++; if (seen !== 1'b0) $display("FAIL mid_ghost: out_valid seen=%b after reset, expected 0", seen); else passed++;
   endtask

`ifdef DRAIN_ROW_MAX_EN
   task automatic test_row_max();
      logic [63:0] v;
      int i;
      do_reset();
      v = {16'h0002, 16'h8000, 16'h0007, 16'hfffd};
      exp_q.push_back(v);
      tick(1'b1, v, 1'b0);
      for (i = 0; i < 12 && !out_valid; i++) tick(1'b0, 64'h0, 1'b0);
      checks++; if (out_valid !== 1'b1) $display("FAIL max_timeout: out_valid=%b after %0d cycles, expected 1", out_valid, i); else passed++;
      checks++; if (out_max !== 16'h0007) $display("FAIL max_value: got %h, expected 0007", out_max); else passed++;
      tick(1'b0, 64'h0, 1'b1);
      checks++; if (out_max !== 16'h0007) $display("FAIL max_hold: got %h, expected 0007", out_max); else passed++;
   endtask
`endif

   initial begin
      reset       = 1'b1;
      array_valid = 1'b0;
      out_ready   = 1'b0;
      psum_bottom = 64'h0;
      for (int i = 0; i < 256; i++) begin
         hist_v[i] = 1'b0;
         hist_d[i] = 64'h0;
      end
      @(negedge clk);
      test_reset();
      test_single();
      test_back_to_back();
      test_credit();
      test_overflow();
      test_full_pop();
      test_stall();
      test_reset_midflight();
`ifdef DRAIN_ROW_MAX_EN
      test_row_max();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
